// File: rtl/divider2.sv
// divider2: sequential restoring divider, one quotient bit per clock.
// It uses the same start/ready handshake as the shift-add multiplier.
//
// Parameters:
//   WIDTH_N     dividend/quotient width (>= 2)
//   WIDTH_D     divisor/remainder width (1..WIDTH_N)
// Ports:
//   clk         clock, rising edge
//   rst_n       asynchronous active-low reset
//   start       load operands and begin a division (wins over a running step)
//   dividend    numerator, sampled only when start=1
//   divisor     denominator, sampled only when start=1
//   quotient    registered quotient (intermediate while busy)
//   remainder   registered remainder (intermediate while busy)
//   ready       high when idle/finished, low while dividing
//   done        one-cycle pulse when a division completes
//   div_by_zero last accepted divisor was zero; held until next start
module divider2 #(
    parameter int unsigned WIDTH_N = 16,
    parameter int unsigned WIDTH_D = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH_N-1:0] dividend,
    input  logic [WIDTH_D-1:0] divisor,
    output logic [WIDTH_N-1:0] quotient,
    output logic [WIDTH_D-1:0] remainder,
    output logic               ready,
    output logic               done,
    output logic               div_by_zero
);

    localparam int unsigned CNT_W = $clog2(WIDTH_N) + 1;
    localparam int unsigned S_W   = WIDTH_D + 1;
    localparam int unsigned T_W   = WIDTH_D + 2;

    localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(WIDTH_N);

    logic [WIDTH_N-1:0] q;
    logic [WIDTH_D-1:0] r;
    logic [WIDTH_D-1:0] dreg;
    logic [CNT_W-1:0]   cnt;

    logic               busy_c;
    logic [S_W-1:0]     s_c;
    logic [T_W-1:0]     t_c;
    logic               fits_c;
    logic [WIDTH_N-1:0] q_step_c;
    logic [WIDTH_D-1:0] r_step_c;
    logic [CNT_W-1:0]   cnt_inc_c;
    logic               last_c;

    // One restoring step: shift in the next dividend bit and try to subtract.
    always_comb begin
        busy_c    = (cnt < CNT_DONE);
        s_c       = {r, q[WIDTH_N-1]};
        t_c       = {1'b0, s_c} - {2'b00, dreg};
        fits_c    = ~t_c[T_W-1];
        q_step_c  = {q[WIDTH_N-2:0], fits_c};
        // With a zero divisor t equals s, so the truncated s is kept.
        r_step_c  = fits_c ? WIDTH_D'(t_c) : WIDTH_D'(s_c);
        cnt_inc_c = cnt + CNT_W'(1);
        last_c    = (cnt_inc_c == CNT_DONE);
    end

    // Datapath, step counter and registered handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q           <= '0;
            r           <= '0;
            dreg        <= '0;
            cnt         <= CNT_DONE;
            ready       <= 1'b1;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
        end else if (start) begin
            q           <= dividend;
            r           <= '0;
            dreg        <= divisor;
            cnt         <= '0;
            ready       <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= (divisor == '0);
        end else if (busy_c) begin
            q     <= q_step_c;
            r     <= r_step_c;
            cnt   <= cnt_inc_c;
            ready <= last_c;
            done  <= last_c;
        end else begin
            done <= 1'b0;
        end
    end

    assign quotient  = q;
    assign remainder = r;

endmodule

// File: tb/tb_divider2.sv
// tb_divider2: directed and random checks of divider2 against an
// arithmetic reference (integer / and %, all-ones on divide by zero).
module tb_divider2;

    localparam int unsigned WN = 16;
    localparam int unsigned WD = 8;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic [WN-1:0] dividend;
    logic [WD-1:0] divisor;
    logic [WN-1:0] quotient;
    logic [WD-1:0] remainder;
    logic          ready;
    logic          done;
    logic          div_by_zero;

    int n_vec;
    int n_err;

    logic [WN-1:0] exp_q;
    logic [WD-1:0] exp_r;
    logic          exp_z;

    divider2 #(.WIDTH_N(WN), .WIDTH_D(WD)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .quotient    (quotient),
        .remainder   (remainder),
        .ready       (ready),
        .done        (done),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference result of a division, straight from the arithmetic definition.
    task automatic model(input logic [WN-1:0] a, input logic [WD-1:0] b);
        logic [WN-1:0] a_v;
        a_v = a;
        if (b == '0) begin
            exp_q = '1;
            exp_r = a_v[WD-1:0];
            exp_z = 1'b1;
        end else begin
            exp_q = a / WN'(b);
            exp_r = WD'(a % WN'(b));
            exp_z = 1'b0;
        end
    endtask

    // Called at a negedge; start is sampled at the next posedge.
    task automatic launch(input logic [WN-1:0] a, input logic [WD-1:0] b);
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        model(a, b);
        @(negedge clk);
        start    = 1'b0;
        dividend = WN'($urandom);
        divisor  = WD'($urandom);
    endtask

    // Returns at the negedge of the done cycle.
    task automatic await_result(input string tag);
        check({tag, "_ready_low0"}, 32'(ready), 32'd0);
        check({tag, "_done_low0"}, 32'(done), 32'd0);
        for (int i = 1; i < int'(WN); i++) begin
            @(negedge clk);
            check({tag, "_ready_low"}, 32'(ready), 32'd0);
            check({tag, "_done_low"}, 32'(done), 32'd0);
        end
        @(negedge clk);
        check({tag, "_ready"}, 32'(ready), 32'd1);
        check({tag, "_done"}, 32'(done), 32'd1);
        check({tag, "_quot"}, 32'(quotient), 32'(exp_q));
        check({tag, "_rem"}, 32'(remainder), 32'(exp_r));
        check({tag, "_dbz"}, 32'(div_by_zero), 32'(exp_z));
    endtask

    task automatic idle_check(input string tag);
        @(negedge clk);
        check({tag, "_done_fall"}, 32'(done), 32'd0);
        check({tag, "_hold_ready"}, 32'(ready), 32'd1);
        check({tag, "_hold_quot"}, 32'(quotient), 32'(exp_q));
        check({tag, "_hold_rem"}, 32'(remainder), 32'(exp_r));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"}, 32'(ready), 32'd1);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_quot"}, 32'(quotient), 32'd0);
        check({tag, "_rem"}, 32'(remainder), 32'd0);
        check({tag, "_dbz"}, 32'(div_by_zero), 32'd0);
    endtask

    initial begin
        n_vec    = 0;
        n_err    = 0;
        rst_n    = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;

        // Asynchronous reset before any clock edge.
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("rst_init");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_reset_outputs("rst_idle");

        // Nominal and boundary operands.
        launch(16'd1000, 8'd7);   await_result("nom");   idle_check("nom");
        launch(16'hFFFF, 8'hFF);  await_result("ffff_ff"); idle_check("ffff_ff");
        launch(16'd5, 8'd10);     await_result("small"); idle_check("small");
        launch(16'd0, 8'd3);      await_result("zero_n"); idle_check("zero_n");
        launch(16'hFFFF, 8'd1);   await_result("by_one"); idle_check("by_one");

        // Divide by zero, then a normal division clears the flag.
        launch(16'h1234, 8'd0);   await_result("dbz");   idle_check("dbz");
        check("dbz_value_q", 32'(quotient), 32'hFFFF);
        check("dbz_value_r", 32'(remainder), 32'h34);
        launch(16'd100, 8'd9);    await_result("after_dbz");
        check("after_dbz_q", 32'(quotient), 32'd11);
        check("after_dbz_r", 32'(remainder), 32'd1);
        idle_check("after_dbz");

        // Restart at step 5: first division never reports done.
        launch(16'd1000, 8'd7);
        repeat (4) @(negedge clk);
        launch(16'd255, 8'd16);   await_result("restart");
        check("restart_q", 32'(quotient), 32'd15);
        check("restart_r", 32'(remainder), 32'd15);
        idle_check("restart");

        // start held for several edges: the last load wins.
        start    = 1'b1;
        dividend = 16'd999;
        divisor  = 8'd4;
        @(negedge clk);
        launch(16'd50000, 8'd123); await_result("held"); idle_check("held");

        // Reset at step 8 of a divide-by-zero run aborts at once.
        launch(16'h1234, 8'd0);
        repeat (7) @(negedge clk);
        check("midrst_busy", 32'(ready), 32'd0);
        check("midrst_dbz_set", 32'(div_by_zero), 32'd1);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_reset_outputs("midrst_after");

        // Back-to-back: second start in the done cycle of the first.
        launch(16'd100, 8'd9);    await_result("b2b_first");
        check("b2b_first_q", 32'(quotient), 32'd11);
        check("b2b_first_r", 32'(remainder), 32'd1);
        launch(16'd77, 8'd5);     await_result("b2b_second");
        check("b2b_second_q", 32'(quotient), 32'd15);
        check("b2b_second_r", 32'(remainder), 32'd2);
        idle_check("b2b_second");

        // Random operands, occasional zero divisor, some back-to-back.
        for (int n = 0; n < 40; n++) begin
            logic [WN-1:0] a;
            logic [WD-1:0] b;
            a = WN'($urandom);
            b = ($urandom_range(0, 7) == 0) ? '0 : WD'($urandom);
            if ($urandom_range(0, 3) == 0) b = WD'($urandom_range(1, 3));
            launch(a, b);
            await_result("rand");
            if ($urandom_range(0, 1) == 0) idle_check("rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/divider2.md
# divider2

Sequential restoring divider that is the inverse of the team's shift-add multiplier. It accepts a 16-bit dividend and an 8-bit divisor on a start strobe and produces quotient and remainder one bit per clock. It has the same start/ready handshake as the multiplier, so the two blocks are interchangeable behind the same controller.

## Interface
- WIDTH_N, 16, dividend and quotient width; must be at least 2.
- WIDTH_D, 8, divisor and remainder width; must be at least 1 and at most WIDTH_N.
- clk  input  1  clock; all state changes on the rising edge.
- rst_n  input  1  reset, asynchronous and active-low.
- start  input  1  load operands and begin a division; sampled on the rising edge of clk.
- dividend  input  WIDTH_N  numerator, unsigned; sampled only on an edge where start=1.
- divisor  input  WIDTH_D  denominator, unsigned; sampled only on an edge where start=1.
- quotient  output  WIDTH_N  unsigned quotient; registered.
- remainder  output  WIDTH_D  unsigned remainder; registered.
- ready  output  1  high when idle or finished; low while a division is running.
- done  output  1  one-cycle pulse on the cycle ready rises after a division.
- div_by_zero  output  1  high when the last accepted divisor was 0; held until the next start.

## Operation
- Internal state:
  - Shift register Q (WIDTH_N bits). It holds the dividend and then the quotient, and drives quotient directly.
  - Partial remainder R (WIDTH_D bits), which drives remainder directly.
  - Registered copy of the divisor, Dreg.
  - Step counter cnt (clog2(WIDTH_N)+1 bits).
- Two states, derived from cnt:
  - BUSY when cnt < WIDTH_N.
  - IDLE when cnt == WIDTH_N.
  - ready = (cnt == WIDTH_N).
- Reset (rst_n=0, asynchronous):
  - cnt=WIDTH_N, Q=0, R=0, Dreg=0.
  - ready=1, done=0, div_by_zero=0.
- Start (start=1 at an edge, in any state):
  - Q=dividend, R=0, Dreg=divisor, cnt=0.
  - div_by_zero=(divisor==0), done=0.
  - start has priority over an in-progress step, so a start while BUSY aborts and restarts the division.
- BUSY step (start=0, cnt<WIDTH_N), performed each edge:
  - s = {R, Q[WIDTH_N-1]}, which is WIDTH_D+1 bits wide.
  - t = s − {1'b0, Dreg}, computed WIDTH_D+2 bits wide with a sign bit.
  - If t is non-negative: R=t[WIDTH_D-1:0] and Q={Q[WIDTH_N-2:0],1}.
  - Otherwise: R=s[WIDTH_D-1:0] and Q={Q[WIDTH_N-2:0],0}.
  - cnt=cnt+1.
  - done=1 when this step makes cnt reach WIDTH_N, else done=0.
- IDLE with start=0:
  - All registers hold.
  - done=0 after its single pulse cycle.
- Divisor 0:
  - The algorithm runs unmodified. Every compare succeeds and the truncated s is kept.
  - Result: quotient = all ones, remainder = dividend[WIDTH_D-1:0], div_by_zero=1.
- Arithmetic: all operands are unsigned.
  - Each successful compare leaves R < Dreg, so R never overflows for non-zero divisors.
  - Final results satisfy dividend = quotient·divisor + remainder, with remainder < divisor.

## Timing
- Start accepted at edge k: ready=0 from just after edge k.
- Edges k+1 … k+WIDTH_N each perform one step.
- Just after edge k+WIDTH_N: ready=1, done=1, and quotient and remainder are final.
- Just after edge k+WIDTH_N+1: done=0.
- Latency from start edge to valid result is WIDTH_N cycles (16 by default).
- Back-to-back operation: start may be asserted in the same cycle that done=1. The next division then begins at that edge, done deasserts, and throughput is one result every WIDTH_N cycles.
- While BUSY, quotient and remainder show intermediate values; they are valid only while ready=1.
- start held high for several edges reloads on every such edge. The division runs from the last edge at which start=1.
- rst_n low mid-division aborts immediately, with no clock edge required. Outputs go to their reset values and no done pulse is produced.
- Operand inputs are ignored when start=0, so they may change freely while BUSY.

## Test plan
- Reset:
  - Stimulus: assert rst_n=0 between clock edges.
  - Required response: ready=1, done=0, quotient=0, remainder=0 and div_by_zero=0, all without a clock edge.
- Nominal division:
  - Stimulus: dividend=1000, divisor=7, start for 1 cycle.
  - Required response: ready=0 for exactly 16 cycles, then quotient=142, remainder=6 and done pulses once.
- Boundary operands, each a separate run:
  - 0xFFFF/0xFF gives quotient=0x0101, remainder=0.
  - 5/10 gives quotient=0, remainder=5.
  - 0/3 gives quotient=0, remainder=0.
  - 0xFFFF/1 gives quotient=0xFFFF, remainder=0.
- Divide by zero:
  - Stimulus: dividend=0x1234, divisor=0.
  - Required response after 16 cycles: div_by_zero=1, quotient=0xFFFF, remainder=0x34.
  - A following start of 100/9 clears div_by_zero and returns quotient=11, remainder=1.
- Restart mid-operation:
  - Stimulus: start 1000/7, then start 255/16 at step 5.
  - Required response: ready rises 16 cycles after the second start with quotient=15, remainder=15, and no done pulse for the first division.
- Reset mid-operation and back-to-back:
  - Stimulus: apply rst_n low at step 8.
  - Required response: ready=1 and outputs zero at once.
  - Then start 77/5 in the done cycle of a preceding 100/9 run.
  - Required response: the first result is quotient=11, remainder=1; the second, 16 cycles later, is quotient=15, remainder=2.
